// File: rtl/alu_arbiter_if.sv
// Request, ALU and response signals of alu_arbiter grouped as one bundle.
// The slave modport is the arbiter side; master is the requesters/ALU/consumer side.
interface alu_arbiter_if #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = 2
);
  logic [N_REQ-1:0]   req_valid;
  logic [N_REQ-1:0]   req_ready;
  logic [8*N_REQ-1:0] req_a;
  logic [8*N_REQ-1:0] req_b;
  logic [4*N_REQ-1:0] req_sel;

  logic [7:0]         alu_a;
  logic [7:0]         alu_b;
  logic [3:0]         alu_sel;
  logic [7:0]         alu_out;
  logic               alu_carry;

  logic               rsp_valid;
  logic               rsp_ready;
  logic [ID_W-1:0]    rsp_id;
  logic [7:0]         rsp_result;
  logic               rsp_carry;
  logic               rsp_dz;

  logic               busy;
  logic [15:0]        op_count;

  modport slave (
    input  req_valid, req_a, req_b, req_sel,
    output req_ready,
    output alu_a, alu_b, alu_sel,
    input  alu_out, alu_carry,
    output rsp_valid, rsp_id, rsp_result, rsp_carry, rsp_dz,
    input  rsp_ready,
    output busy, op_count
  );

  modport master (
    output req_valid, req_a, req_b, req_sel,
    input  req_ready,
    input  alu_a, alu_b, alu_sel,
    output alu_out, alu_carry,
    input  rsp_valid, rsp_id, rsp_result, rsp_carry, rsp_dz,
    output rsp_ready,
    input  busy, op_count
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one combinational 8-bit ALU among N_REQ requesters:
// grant in IDLE, drive the ALU from registered operands in EXEC, hold the response in RESP.
module alu_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = 2
) (
  input logic         clk,
  input logic         rst_n,
  alu_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_e;

  state_e          state_q;
  logic [7:0]      op_a_q;
  logic [7:0]      op_b_q;
  logic [3:0]      op_sel_q;
  logic [7:0]      res_q;
  logic            carry_q;
  logic            dz_q;
  logic            rsp_valid_q;
  logic            busy_q;
  logic [ID_W-1:0] cur_id_q;
  logic [ID_W-1:0] last_grant_q;
  logic [15:0]     op_count_q;
  logic [15:0]     op_count_d;

  logic            grant_vld;
  logic [ID_W-1:0] grant_idx;
  logic [ID_W-1:0] cand;
  logic [7:0]      win_a;
  logic [7:0]      win_b;
  logic [3:0]      win_sel;

  // Search starts one past the last grant so every pending requester is reached within N_REQ visits.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      cand = ID_W'((32'(last_grant_q) + k) % N_REQ);
      if (!grant_vld && bus.req_valid[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  always_comb begin
    win_a         = '0;
    win_b         = '0;
    win_sel       = '0;
    bus.req_ready = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (grant_idx == ID_W'(i)) begin
        win_a   = bus.req_a[8*i +: 8];
        win_b   = bus.req_b[8*i +: 8];
        win_sel = bus.req_sel[4*i +: 4];
      end
      bus.req_ready[i] = (state_q == IDLE) && grant_vld && (grant_idx == ID_W'(i));
    end
  end

  assign op_count_d = op_count_q + 16'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      op_a_q       <= '0;
      op_b_q       <= '0;
      op_sel_q     <= '0;
      res_q        <= '0;
      carry_q      <= 1'b0;
      dz_q         <= 1'b0;
      rsp_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      cur_id_q     <= '0;
      last_grant_q <= ID_W'(N_REQ - 1);
      op_count_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_vld) begin
            op_a_q       <= win_a;
            op_b_q       <= win_b;
            op_sel_q     <= win_sel;
            cur_id_q     <= grant_idx;
            last_grant_q <= grant_idx;
            busy_q       <= 1'b1;
            state_q      <= EXEC;
          end
        end
        EXEC: begin
          if (op_sel_q == 4'b0011 && op_b_q == '0) begin
            res_q <= '1;
            dz_q  <= 1'b1;
          end else begin
            res_q <= bus.alu_out;
            dz_q  <= 1'b0;
          end
          carry_q     <= (op_sel_q == 4'b0000) && bus.alu_carry;
          rsp_valid_q <= 1'b1;
          state_q     <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            op_count_q  <= op_count_d;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.alu_a      = op_a_q;
  assign bus.alu_b      = op_b_q;
  assign bus.alu_sel    = op_sel_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = cur_id_q;
  assign bus.rsp_result = res_q;
  assign bus.rsp_carry  = carry_q;
  assign bus.rsp_dz     = dz_q;
  assign bus.busy       = busy_q;
  assign bus.op_count   = op_count_q;

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Round-robin arbiter and sequencer that shares the single combinational 8-bit ALU among `N_REQ` requesters. Each requester presents operands and a 4-bit ALU select under a valid/ready handshake. The block grants one request at a time, drives the ALU from registered operands, and captures the result. It returns the result on a shared response channel tagged with the requester index. It sits between the datapath clients (register-file read ports, address generators) and the ALU instance.

## Interface
- `N_REQ`, 4, number of requesters (2..8)
- `ID_W`, 2, width of requester index; must equal clog2(`N_REQ`)
- `clk` input 1: single clock, rising-edge
- `rst_n` input 1: asynchronous, active-low reset
- `req_valid` input `N_REQ`: per-requester request valid
- `req_ready` output `N_REQ`: per-requester accept; at most one bit high
- `req_a` input 8*`N_REQ`: operand A, requester i at [8i+7:8i]
- `req_b` input 8*`N_REQ`: operand B, same packing
- `req_sel` input 4*`N_REQ`: ALU select, requester i at [4i+3:4i]
- `alu_a` output 8: to ALU A
- `alu_b` output 8: to ALU B
- `alu_sel` output 4: to ALU select
- `alu_out` input 8: from ALU result
- `alu_carry` input 1: from ALU carry-out
- `rsp_valid` output 1: response valid
- `rsp_ready` input 1: response accept
- `rsp_id` output `ID_W`: index of the requester that owns the response
- `rsp_result` output 8: captured result
- `rsp_carry` output 1: carry; `alu_carry` when sel=0000, else 0
- `rsp_dz` output 1: divide-by-zero flag
- `busy` output 1: high in any state other than IDLE
- `op_count` output 16: completed-response counter

## Operation
- FSM states: IDLE, EXEC, RESP.
- **IDLE**
  - If any `req_valid` is high, select winner g by round-robin: search from `last_grant+1`, wrapping modulo `N_REQ`.
  - `req_ready[g]`=1 combinationally, only in IDLE.
  - On the edge, latch `req_a[g]`, `req_b[g]` and `req_sel[g]` into `op_a`, `op_b`, `op_sel`; set `cur_id`=g and `last_grant`=g; go to EXEC.
  - If no request is valid, stay in IDLE.
- **EXEC**
  - `alu_a`/`alu_b`/`alu_sel` are driven from `op_a`/`op_b`/`op_sel`. These three are registered outputs and are stable throughout EXEC.
  - On the edge, capture `alu_out` into `res`, capture the carry rule into `carry_r`, and go to RESP.
  - Divide-by-zero: when `op_sel`=0011 and `op_b`=0, set `res`=8'hFF and `dz_r`=1, ignoring `alu_out`. Otherwise `dz_r`=0.
- **RESP**
  - `rsp_valid`=1; `rsp_id`, `rsp_result`, `rsp_carry` and `rsp_dz` are held stable.
  - On `rsp_valid`&`rsp_ready`: `op_count` increments (wraps 16'hFFFF to 0) and the FSM goes to IDLE.
  - Without `rsp_ready`, the FSM holds indefinitely. No new request is accepted while in RESP.
- In IDLE and RESP, the `alu_*` outputs keep the last latched operands; they are not gated.
- Requests that are not granted stay pending. A requester may drop `req_valid` before it is granted; the arbiter takes no action.
- Multiple simultaneous `req_valid`: exactly one grant per IDLE cycle. A single persistent requester is re-granted on every IDLE visit.

## Timing
- Reset, asynchronous on `rst_n`=0:
  - FSM returns to IDLE.
  - `req_ready`=0 (until the next IDLE evaluation), `rsp_valid`=0, `busy`=0, `op_count`=0.
  - `op_a`/`op_b`/`op_sel`/`res`=0, `carry_r`=`dz_r`=0, `rsp_id`=0.
  - `last_grant`=`N_REQ`-1, so requester 0 wins first.
- Reset mid-operation aborts the in-flight op. No response is produced and `op_count` is unchanged from 0.
- Latency: request accepted at edge k, EXEC during cycle k+1, `rsp_valid` high from edge k+2.
- Minimum spacing between accepts: 3 cycles (accept, EXEC, RESP with `rsp_ready`=1).
- `req_ready` depends combinationally on `req_valid` and state. `rsp_valid` and all `rsp_*` data come directly from registers.

## Test plan
- **Single op:** reset; req0 valid with A=8'h0F, B=8'h01, sel=0000, `rsp_ready`=1 → accept at edge 1, `rsp_valid` at edge 3 with result=8'h10, carry=0, id=0, `op_count`=1.
- **Carry and carry masking:** A=8'hFF, B=8'h01, sel=0000 → result 8'h00, carry=1. Same operands with sel=1000 → result 8'h01, carry=0.
- **Round-robin:** all 4 requesters valid continuously → grant order 0,1,2,3,0. Each response's `rsp_id` matches its grant.
- **Divide-by-zero:** A=8'h20, B=0, sel=0011 → result 8'hFF, dz=1. Next op with A=8'h20, B=8'h04, sel=0011 → result 8'h08, dz=0.
- **Backpressure:** `rsp_ready`=0 for 5 cycles in RESP → `rsp_*` stable, all `req_ready`=0, `busy`=1. Release → `op_count` +1, return to IDLE.
- **Reset mid-op:** assert `rst_n`=0 during EXEC → `rsp_valid`=0 immediately, `op_count`=0, next grant goes to requester 0.
